// File: rtl/mem_access_stage.sv
// mem_access_stage: RV32I memory-access stage with a word-organised data RAM
// and a registered MEM/WB bundle (one-cycle latency, stall hold, fault flag).
module mem_access_stage #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        stall,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [4:0]  rd_in,
  input  logic        reg_write_in,
  output logic        valid_out,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        mem_fault
);
  logic [31:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic active, bad_f3, misalign, fault, is_load, we;
  logic [3:0] be;
  logic [31:0] wd, rword, ld_data;
  logic [15:0] sh_w;
  logic valid_q, valid_d, rw_q, rw_d, fault_q, fault_d;
  logic [31:0] data_q, data_d;
  logic [4:0] rd_q, rd_d;
  assign idx = addr[ADDR_W+1:2];
  always_comb begin
    active   = valid_in & ~stall & ~rst;
    bad_f3   = (funct3 == 3'b011) | (&funct3[2:1]) | (mem_write & funct3[2]);
    misalign = funct3[1] ? |addr[1:0] : funct3[0] & addr[0];
    fault    = (mem_read | mem_write) & (bad_f3 | misalign);
    is_load  = mem_read & ~mem_write & ~fault;
    we       = active & mem_write & ~fault;
    be       = funct3[1] ? 4'hf : funct3[0] ? (addr[1] ? 4'hc : 4'h3) : 4'b0001 << addr[1:0];
    wd       = funct3[1] ? wdata : funct3[0] ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
    rword    = mem_q[idx];
    sh_w     = 16'(rword >> {addr[1:0], 3'b000});
    // funct3[2] marks the unsigned loads, which suppresses sign replication
    ld_data  = funct3[1] ? rword :
               funct3[0] ? {{16{~funct3[2] & sh_w[15]}}, sh_w} :
                           {{24{~funct3[2] & sh_w[7]}}, sh_w[7:0]};
    valid_d  = active ? 1'b1 : stall & valid_q;
    data_d   = active ? (is_load ? ld_data : addr) : data_q;
    rd_d     = active ? rd_in : rd_q;
    rw_d     = active ? reg_write_in & ~fault & ~mem_write : rw_q;
    fault_d  = active ? fault : fault_q;
  end
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we & be[i]) mem_q[idx][i*8 +: 8] <= wd[i*8 +: 8];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      fault_q <= fault_d;
    end
  assign valid_out    = valid_q;
  assign wb_data      = data_q;
  assign wb_rd        = rd_q;
  assign wb_reg_write = rw_q;
  assign mem_fault    = fault_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed plan plus random traffic checked against a
// byte-addressed reference model of the memory-access stage.
module tb_mem_access_stage;
  logic clk = 1'b0, rst = 1'b1;
  logic valid_in, stall, mem_read, mem_write, reg_write_in;
  logic [2:0] funct3;
  logic [31:0] addr, wdata;
  logic [4:0] rd_in;
  logic valid_out, wb_reg_write, mem_fault;
  logic [31:0] wb_data;
  logic [4:0] wb_rd;
  int checks = 0, failures = 0;
  logic [7:0] ref_mem [1024];
  logic e_valid = 0, e_rw = 0, e_fault = 0;
  logic [31:0] e_data = 0;
  logic [4:0] e_rd = 0;

  mem_access_stage dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .stall(stall),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rd_in(rd_in), .reg_write_in(reg_write_in),
    .valid_out(valid_out), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("valid_out", {31'b0, valid_out}, {31'b0, e_valid});
    check("wb_data", wb_data, e_data);
    check("wb_rd", {27'b0, wb_rd}, {27'b0, e_rd});
    check("wb_reg_write", {31'b0, wb_reg_write}, {31'b0, e_rw});
    check("mem_fault", {31'b0, mem_fault}, {31'b0, e_fault});
  endtask

  task automatic model();
    int n, a;
    logic st, ld, illegal, fault;
    logic [31:0] v;
    if (rst) begin
      e_valid = 0; e_data = 0; e_rd = 0; e_rw = 0; e_fault = 0;
    end else if (valid_in && !stall) begin
      st = mem_write;
      ld = mem_read && !mem_write;
      illegal = funct3 == 3 || funct3 == 6 || funct3 == 7 || (st && (funct3 == 4 || funct3 == 5));
      n = (funct3 % 4 == 0) ? 1 : (funct3 % 4 == 1) ? 2 : 4;
      a = int'(addr % 1024);
      fault = (mem_read || mem_write) && (illegal || (a % n) != 0);
      e_valid = 1;
      e_rd = rd_in;
      e_fault = fault;
      e_rw = (fault || st) ? 1'b0 : reg_write_in;
      e_data = addr;
      if (!fault && ld) begin
        v = 0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a+i]) << (8*i));
        if (funct3 < 4 && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        e_data = v;
      end
      if (!fault && st)
        for (int i = 0; i < n; i++) ref_mem[a+i] = 8'(wdata >> (8*i));
    end else if (!stall) e_valid = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model();
    #1;
    check_all();
  endtask

  task automatic drive(input logic v, input logic s, input logic r, input logic w,
                       input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] rdx, input logic rw);
    valid_in = v; stall = s; mem_read = r; mem_write = w; funct3 = f;
    addr = a; wdata = d; rd_in = rdx; reg_write_in = rw;
  endtask

  task automatic op(input logic r, input logic w, input logic [2:0] f, input logic [31:0] a,
                    input logic [31:0] d, input logic [4:0] rdx, input logic rw);
    drive(1, 0, r, w, f, a, d, rdx, rw);
    step();
  endtask

  initial begin
    logic [2:0] f;
    logic [31:0] a;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check_all();
    rst = 0;
    for (int i = 0; i < 256; i++) op(0, 1, 3'b010, 32'(i*4), $urandom, 0, 0);
    // directed plan
    op(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0);
    op(1, 0, 3'b010, 32'h10, 0, 5, 1);
    check("plan_lw_data", wb_data, 32'hDEADBEEF);
    check("plan_lw_rd", {27'b0, wb_rd}, 32'd5);
    check("plan_lw_rw", {31'b0, wb_reg_write}, 32'd1);
    op(0, 1, 3'b000, 32'h11, 32'h000000AA, 0, 0);
    op(1, 0, 3'b010, 32'h10, 0, 1, 1);
    check("plan_lw_merge", wb_data, 32'hDEADAAEF);
    op(1, 0, 3'b000, 32'h11, 0, 2, 1);
    check("plan_lb", wb_data, 32'hFFFFFFAA);
    op(1, 0, 3'b100, 32'h11, 0, 3, 1);
    check("plan_lbu", wb_data, 32'h000000AA);
    op(1, 0, 3'b001, 32'h12, 0, 4, 1);
    check("plan_lh", wb_data, 32'hFFFFDEAD);
    op(1, 0, 3'b101, 32'h12, 0, 6, 1);
    check("plan_lhu", wb_data, 32'h0000DEAD);
    op(1, 0, 3'b010, 32'h13, 0, 8, 1);
    check("plan_mis_fault", {31'b0, mem_fault}, 32'd1);
    check("plan_mis_data", wb_data, 32'h13);
    op(0, 1, 3'b001, 32'h21, 32'h0000FFFF, 0, 0);
    op(1, 0, 3'b010, 32'h20, 0, 9, 1);
    op(0, 0, 3'b000, 32'h12345678, 0, 7, 1);
    check("plan_alu_data", wb_data, 32'h12345678);
    check("plan_alu_rd", {27'b0, wb_rd}, 32'd7);
    drive(1, 1, 0, 1, 3'b010, 32'h30, 32'hCAFEF00D, 3, 1);
    repeat (3) step();
    op(1, 0, 3'b010, 32'h30, 0, 10, 1);
    op(0, 1, 3'b010, 32'h400, 32'h1, 0, 0);
    op(1, 0, 3'b010, 32'h0, 0, 11, 1);
    check("plan_wrap", wb_data, 32'h1);
    drive(1, 1, 0, 1, 3'b010, 32'h40, 32'h55, 12, 1);
    step();
    rst = 1;
    #1;
    model();
    check_all();
    drive(1, 0, 0, 1, 3'b010, 32'h40, 32'h55, 12, 1);
    step();
    rst = 0;
    op(1, 0, 3'b010, 32'h40, 0, 13, 1);
    // random traffic
    for (int k = 0; k < 2000; k++) begin
      f = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
      if (f <= 2 && $urandom_range(0, 1) == 1) f = f | 3'b100;
      if (f == 3'b110) f = 3'b010;
      a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 4) != 0) a = a & ~((f[1:0] == 2'b10) ? 32'h3 : (f[1:0] == 2'b01) ? 32'h1 : 32'h0);
      drive($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 15, 1'($urandom), 1'($urandom),
            f, a, $urandom, 5'($urandom), 1'($urandom));
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
